// File: rtl/apb_bridge_if.sv
// Core load-store request/response port plus APB4 master port of apb_bridge.
// "master" is the bridge's view; "slave" is the view of whatever surrounds it.
interface apb_bridge_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int APB_ADDR_WIDTH = 16
);
  // Request side: a transfer is accepted in a cycle where req_valid_i and
  // req_ready_o are both high; the requester holds all req_* fields stable
  // until then. Responses are single-cycle rsp_valid_o pulses with no
  // backpressure, exactly one per accepted request.
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [ADDR_WIDTH-1:0]     req_addr_i;
  logic                      req_we_i;
  logic [DATA_WIDTH-1:0]     req_wdata_i;
  logic [DATA_WIDTH/8-1:0]   req_wstrb_i;
  logic                      rsp_valid_o;
  logic [DATA_WIDTH-1:0]     rsp_rdata_o;
  logic                      rsp_err_o;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_wstrb_i,
    input  prdata, pready, pslverr,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output paddr, psel, penable, pwrite, pwdata, pstrb
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_wstrb_i,
    output prdata, pready, pslverr,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  paddr, psel, penable, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/apb_bridge.sv
// Single-outstanding bridge from the core valid/ready load-store port to APB4.
// Every output is registered; the FSM state is visible on dbg_state.
module apb_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    APB_ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0200_0000,
  parameter bit                    RDATA_DELAYED  = 1'b1,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  apb_bridge_if.master bus,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
  localparam bit         TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_e     state;
  logic [7:0] wait_cnt;
  logic       err_q;
  logic       in_window;

  assign in_window = (bus.req_addr_i[ADDR_WIDTH-1:APB_ADDR_WIDTH] ==
                      BASE_ADDR[ADDR_WIDTH-1:APB_ADDR_WIDTH]);
  assign dbg_state = state;

  // Outputs are loaded on the transition into the state that shows them, so
  // psel/penable are flops and drop asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      err_q           <= 1'b0;
      bus.req_ready_o <= 1'b1;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.rsp_err_o   <= 1'b0;
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= '0;
      bus.pwdata      <= '0;
      bus.pstrb       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            bus.req_ready_o <= 1'b0;
            if (in_window) begin
              state       <= SETUP;
              wait_cnt    <= '0;
              err_q       <= 1'b0;
              bus.psel    <= 1'b1;
              bus.penable <= 1'b0;
              bus.paddr   <= bus.req_addr_i[APB_ADDR_WIDTH-1:0];
              bus.pwrite  <= bus.req_we_i;
              bus.pwdata  <= bus.req_wdata_i;
              bus.pstrb   <= bus.req_we_i ? bus.req_wstrb_i : '0;
            end else begin
              state           <= RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_rdata_o <= '0;
            end
          end
        end

        SETUP: begin
          state       <= ACCESS;
          bus.penable <= 1'b1;
        end

        ACCESS: begin
          if (bus.pready) begin
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            err_q       <= bus.pslverr;
            if (bus.pwrite || !RDATA_DELAYED) begin
              state           <= RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_err_o   <= bus.pslverr;
              bus.rsp_rdata_o <= (bus.pwrite || bus.pslverr) ? '0 : bus.prdata;
            end else begin
              state <= CAPTURE;
            end
          end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_LIM)) begin
            state           <= RESP;
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_err_o   <= 1'b1;
            bus.rsp_rdata_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        // Registered-read slaves present prdata one cycle after completion.
        CAPTURE: begin
          state           <= RESP;
          bus.rsp_valid_o <= 1'b1;
          bus.rsp_err_o   <= err_q;
          bus.rsp_rdata_o <= err_q ? '0 : bus.prdata;
        end

        RESP: begin
          state           <= IDLE;
          bus.req_ready_o <= 1'b1;
          bus.rsp_valid_o <= 1'b0;
          bus.rsp_err_o   <= 1'b0;
          bus.rsp_rdata_o <= '0;
        end

        default: begin
          state           <= IDLE;
          bus.req_ready_o <= 1'b1;
          bus.rsp_valid_o <= 1'b0;
          bus.psel        <= 1'b0;
          bus.penable     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge.sv
// Directed bench for apb_bridge: dut_a uses a registered-read slave with a
// 4-cycle timeout, dut_b samples prdata in ACCESS; both share the APB slave.
module tb_apb_bridge;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int PAW = 16;
  localparam int SW  = DW / 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  logic        clk;
  logic        reset_n;
  logic [2:0]  dbg_a;
  logic [2:0]  dbg_b;
  int          checks = 0;
  int          errors = 0;
  logic [DW:0] exp_q[$];

  apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(PAW)) bus_a ();
  apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(PAW)) bus_b ();

  apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(PAW),
    .BASE_ADDR(32'h0200_0000), .RDATA_DELAYED(1'b1), .TIMEOUT_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .dbg_state(dbg_a)
  );

  apb_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .APB_ADDR_WIDTH(PAW),
    .BASE_ADDR(32'h0200_0000), .RDATA_DELAYED(1'b0), .TIMEOUT_CYCLES(255)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .dbg_state(dbg_b)
  );

  assign bus_b.prdata  = bus_a.prdata;
  assign bus_b.pready  = bus_a.pready;
  assign bus_b.pslverr = bus_a.pslverr;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic to_a, input logic to_b, input logic [AW-1:0] addr,
                           input logic we, input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
    bus_a.req_valid_i = to_a;
    bus_a.req_addr_i  = addr;
    bus_a.req_we_i    = we;
    bus_a.req_wdata_i = wdata;
    bus_a.req_wstrb_i = wstrb;
    bus_b.req_valid_i = to_b;
    bus_b.req_addr_i  = addr;
    bus_b.req_we_i    = we;
    bus_b.req_wdata_i = wdata;
    bus_b.req_wstrb_i = wstrb;
  endtask

  task automatic idle_req();
    bus_a.req_valid_i = 1'b0;
    bus_b.req_valid_i = 1'b0;
  endtask

  // Called one cycle after acceptance; returns latency from acceptance and
  // number of penable cycles seen, then scores the response against exp_q.
  task automatic wait_rsp(input string tag, input int max_cyc, output int lat, output int acc);
    logic [DW:0] exp;
    lat = 1;
    acc = 0;
    while (!bus_a.rsp_valid_o && lat < max_cyc) begin
      if (bus_a.penable) acc++;
      step();
      lat++;
    end
    check({tag, "_rsp_seen"}, 64'(bus_a.rsp_valid_o), 64'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_err"}, 64'(bus_a.rsp_err_o), 64'(exp[DW]));
    check({tag, "_rdata"}, 64'(bus_a.rsp_rdata_o), 64'(exp[DW-1:0]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int acc;
    drive_req(1'b0, 1'b0, '0, 1'b0, '0, '0);
    bus_a.prdata  = '0;
    bus_a.pready  = 1'b0;
    bus_a.pslverr = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;

    check("rst_ready",   64'(bus_a.req_ready_o), 64'd1);
    check("rst_rvalid",  64'(bus_a.rsp_valid_o), 64'd0);
    check("rst_rdata",   64'(bus_a.rsp_rdata_o), 64'd0);
    check("rst_rerr",    64'(bus_a.rsp_err_o),   64'd0);
    check("rst_psel",    64'(bus_a.psel),        64'd0);
    check("rst_penable", 64'(bus_a.penable),     64'd0);
    check("rst_pwrite",  64'(bus_a.pwrite),      64'd0);
    check("rst_paddr",   64'(bus_a.paddr),       64'd0);
    check("rst_pwdata",  64'(bus_a.pwdata),      64'd0);
    check("rst_pstrb",   64'(bus_a.pstrb),       64'd0);
    check("rst_state",   64'(dbg_a),             64'(ST_IDLE));
    step();
    step();
    reset_n = 1'b1;
    step();

    // ---- write 0x1234_5678 to 0x0200_4000, no wait states ----
    check("wr_ready_T", 64'(bus_a.req_ready_o), 64'd1);
    drive_req(1'b1, 1'b0, 32'h0200_4000, 1'b1, 32'h1234_5678, 4'hF);
    bus_a.pready = 1'b1;
    step();                                             // T+1
    idle_req();
    check("wr_setup_psel",    64'(bus_a.psel),        64'd1);
    check("wr_setup_penable", 64'(bus_a.penable),     64'd0);
    check("wr_setup_ready",   64'(bus_a.req_ready_o), 64'd0);
    step();                                             // T+2
    check("wr_acc_psel",    64'(bus_a.psel),    64'd1);
    check("wr_acc_penable", 64'(bus_a.penable), 64'd1);
    check("wr_acc_paddr",   64'(bus_a.paddr),   64'h4000);
    check("wr_acc_pwrite",  64'(bus_a.pwrite),  64'd1);
    check("wr_acc_pwdata",  64'(bus_a.pwdata),  64'h1234_5678);
    check("wr_acc_pstrb",   64'(bus_a.pstrb),   64'hF);
    check("wr_acc_rvalid",  64'(bus_a.rsp_valid_o), 64'd0);
    step();                                             // T+3
    check("wr_rsp_valid", 64'(bus_a.rsp_valid_o), 64'd1);
    check("wr_rsp_err",   64'(bus_a.rsp_err_o),   64'd0);
    check("wr_rsp_rdata", 64'(bus_a.rsp_rdata_o), 64'd0);
    check("wr_rsp_psel",  64'(bus_a.psel),        64'd0);
    step();                                             // T+4
    check("wr_done_valid", 64'(bus_a.rsp_valid_o), 64'd0);
    check("wr_done_ready", 64'(bus_a.req_ready_o), 64'd1);

    // ---- read 0x0200_BFF8 on both bridges ----
    drive_req(1'b1, 1'b1, 32'h0200_BFF8, 1'b0, 32'hDEAD_BEEF, 4'hF);
    bus_a.prdata = 32'h1111_2222;
    step();                                             // T+1
    idle_req();
    check("rd_setup_psel_a", 64'(bus_a.psel), 64'd1);
    check("rd_setup_psel_b", 64'(bus_b.psel), 64'd1);
    step();                                             // T+2 ACCESS
    check("rd_acc_paddr",  64'(bus_a.paddr),   64'hBFF8);
    check("rd_acc_pwrite", 64'(bus_a.pwrite),  64'd0);
    check("rd_acc_pstrb",  64'(bus_a.pstrb),   64'd0);
    check("rd_acc_pen",    64'(bus_a.penable), 64'd1);
    bus_a.prdata = 32'h5555_AAAA;
    step();                                             // T+3
    check("rdb_rsp_valid", 64'(bus_b.rsp_valid_o), 64'd1);
    check("rdb_rsp_rdata", 64'(bus_b.rsp_rdata_o), 64'h5555_AAAA);
    check("rdb_rsp_err",   64'(bus_b.rsp_err_o),   64'd0);
    check("rda_cap_state", 64'(dbg_a),             64'(ST_CAPTURE));
    check("rda_cap_psel",  64'(bus_a.psel),        64'd0);
    check("rda_cap_valid", 64'(bus_a.rsp_valid_o), 64'd0);
    bus_a.prdata = 32'hCAFE_0001;
    step();                                             // T+4
    bus_a.prdata = '0;
    check("rda_rsp_valid", 64'(bus_a.rsp_valid_o), 64'd1);
    check("rda_rsp_rdata", 64'(bus_a.rsp_rdata_o), 64'hCAFE_0001);
    check("rda_rsp_err",   64'(bus_a.rsp_err_o),   64'd0);
    check("rdb_after",     64'(bus_b.rsp_valid_o), 64'd0);
    step();
    check("rd_done_ready", 64'(bus_a.req_ready_o), 64'd1);

    // ---- read with 3 wait states then slave error ----
    drive_req(1'b1, 1'b0, 32'h0200_0010, 1'b0, '0, 4'hF);
    bus_a.pready = 1'b0;
    step();                                             // T+1
    idle_req();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      step();                                           // T+2 .. T+5
      if (bus_a.penable) acc++;
      if (i == 3) begin
        bus_a.pready  = 1'b1;
        bus_a.pslverr = 1'b1;
      end
    end
    step();                                             // T+6 CAPTURE
    bus_a.pready  = 1'b0;
    bus_a.pslverr = 1'b0;
    bus_a.prdata  = 32'hFFFF_FFFF;
    check("ws_access_cycles", 64'(acc),          64'd4);
    check("ws_cap_state",     64'(dbg_a),        64'(ST_CAPTURE));
    check("ws_cap_penable",   64'(bus_a.penable), 64'd0);
    step();                                             // T+7 RESP
    bus_a.prdata = '0;
    check("ws_rsp_valid", 64'(bus_a.rsp_valid_o), 64'd1);
    check("ws_rsp_err",   64'(bus_a.rsp_err_o),   64'd1);
    check("ws_rsp_rdata", 64'(bus_a.rsp_rdata_o), 64'd0);
    step();

    // ---- out-of-window access ----
    drive_req(1'b1, 1'b0, 32'h0300_0000, 1'b0, '0, 4'hF);
    bus_a.pready = 1'b1;
    step();                                             // T+1
    idle_req();
    check("oow_rsp_valid", 64'(bus_a.rsp_valid_o), 64'd1);
    check("oow_rsp_err",   64'(bus_a.rsp_err_o),   64'd1);
    check("oow_rsp_rdata", 64'(bus_a.rsp_rdata_o), 64'd0);
    check("oow_psel_t1",   64'(bus_a.psel),        64'd0);
    step();                                             // T+2
    check("oow_psel_t2",  64'(bus_a.psel),        64'd0);
    check("oow_valid_t2", 64'(bus_a.rsp_valid_o), 64'd0);
    check("oow_ready_t2", 64'(bus_a.req_ready_o), 64'd1);

    // ---- timeout: pready stuck low, TIMEOUT_CYCLES=4 ----
    drive_req(1'b1, 1'b0, 32'h0200_0100, 1'b1, 32'hAAAA_5555, 4'h3);
    bus_a.pready = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    step();
    idle_req();
    wait_rsp("to", 20, lat, acc);
    check("to_latency",  64'(lat),           64'd7);
    check("to_access",   64'(acc),           64'd5);
    check("to_rsp_psel", 64'(bus_a.psel),    64'd0);
    check("to_rsp_pen",  64'(bus_a.penable), 64'd0);
    step();
    check("to_idle_ready", 64'(bus_a.req_ready_o), 64'd1);
    drive_req(1'b1, 1'b0, 32'h0200_0104, 1'b1, 32'h0BAD_F00D, 4'hF);
    bus_a.pready = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    step();
    idle_req();
    wait_rsp("to_next", 20, lat, acc);
    check("to_next_latency", 64'(lat), 64'd3);
    check("to_next_access",  64'(acc), 64'd1);
    step();

    // ---- reset during ACCESS ----
    drive_req(1'b1, 1'b0, 32'h0200_0200, 1'b1, 32'h7777_8888, 4'hF);
    bus_a.pready = 1'b0;
    step();                                             // T+1
    idle_req();
    step();                                             // T+2 ACCESS
    check("rr_acc_penable", 64'(bus_a.penable), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rr_psel",    64'(bus_a.psel),    64'd0);
    check("rr_penable", 64'(bus_a.penable), 64'd0);
    check("rr_state",   64'(dbg_a),         64'(ST_IDLE));
    step();
    check("rr_no_rsp", 64'(bus_a.rsp_valid_o), 64'd0);
    reset_n = 1'b1;
    step();
    check("rr_ready",   64'(bus_a.req_ready_o), 64'd1);
    check("rr_no_rsp2", 64'(bus_a.rsp_valid_o), 64'd0);
    drive_req(1'b1, 1'b0, 32'h0200_0300, 1'b1, 32'h0102_0304, 4'hF);
    bus_a.pready = 1'b1;
    exp_q.push_back({1'b0, 32'h0});
    step();
    idle_req();
    wait_rsp("rr_wr", 20, lat, acc);
    check("rr_wr_latency", 64'(lat), 64'd3);
    check("rr_wr_access",  64'(acc), 64'd1);
    step();
    check("end_state_a", 64'(dbg_a), 64'(ST_IDLE));
    check("end_state_b", 64'(dbg_b), 64'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
